input_ram_ctrl: RTL and testbench
=================================

# input_ram_ctrl

Line-buffer sequencer for the two-line input RAM matrix in the video scaling path. It resets the matrix per frame and requests source lines from the DDR reader. It steers incoming DDR pixel beats into the ping-pong line slots and keeps source rows y and y+1 resident for the compute unit. It then drives the matrix read side so the "top" outputs (00/01) come from row y and the "bottom" outputs (10/11) come from row y+1.

## Interface
- IMAGE_WIDTH, 11, bit width of all width, height, coordinate and address fields.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse; starts or restarts a frame.
- i_src_width  in  IMAGE_WIDTH  source line width W in pixels; sampled at i_frame_start; W>=2.
- i_src_height  in  IMAGE_WIDTH  source height H; sampled at i_frame_start; H>=2.
- o_ddr_rd_req  out  1  one-cycle pulse; asks the DDR reader for one full line.
- o_ddr_rd_line  out  IMAGE_WIDTH  line index for the request; held until the next request.
- i_ddr_data_valid  in  1  one pixel beat on the DDR data bus, which feeds the matrix directly.
- o_fifo_i_rst  out  1  matrix reset.
- o_fifo_i_wr_line  out  1  slot being written.
- o_fifo_i_wr_addr  out  IMAGE_WIDTH  write address.
- o_fifo_i_wr_en  out  1  write enable.
- i_row_req  in  1  compute unit asks for source rows i_row_y, i_row_y+1.
- i_row_y  in  IMAGE_WIDTH  requested top row; nondecreasing within a frame.
- o_row_ready  out  1  requested rows are resident and the read side is valid.
- i_rd_en  in  1  compute read strobe; honored only while o_row_ready=1.
- i_rd_x  in  IMAGE_WIDTH  source column to read.
- o_fifo_i_rd_line  out  1  slot holding the top row.
- o_fifo_i_rd_addr  out  IMAGE_WIDTH  read address.
- o_pix_valid  out  1  matrix pixel outputs valid for the corresponding i_rd_en.

## Operation
- State registers:
  - top_y: index of the top resident row.
  - top_slot: slot holding top_y; the other slot holds top_y+1.
  - wr_cnt: beat counter.
  - Latched W and H.
- States: IDLE, RST, REQ, FILL, CHECK, READY.
- IDLE: wait for i_frame_start.
- i_frame_start in any state (highest priority):
  - Latch W and H.
  - Set top_y=0, top_slot=0, fill_idx=0.
  - Go to RST.
- RST (1 cycle): o_fifo_i_rst=1, then go to REQ.
- REQ (1 cycle):
  - o_ddr_rd_req=1, with o_ddr_rd_line = line being fetched.
  - wr_line = target slot; wr_cnt=0.
  - Go to FILL.
- FILL:
  - o_fifo_i_wr_en = i_ddr_data_valid (combinational).
  - o_fifo_i_wr_addr = wr_cnt; wr_cnt increments per beat.
  - The beat with wr_cnt==W-1 ends the line; go to CHECK.
  - Beats outside FILL are ignored (wr_en=0).
- Initial fill:
  - Line 0 goes to slot 0, then line 1 goes to slot 1.
  - Then wait in CHECK with o_row_ready=0 until i_row_req.
- Target row:
  - y_t = min(i_row_y, H-2), captured on an accepted i_row_req.
  - i_row_req is accepted in CHECK or READY, and only after the initial fill.
- CHECK:
  - If top_y == y_t, go to READY.
  - Otherwise fetch line top_y+2 into slot top_slot, overwriting the oldest row. On completion, toggle top_slot and increment top_y. Repeat.
  - A request with y_t < top_y (rows going backward) is treated as y_t = top_y.
- READY:
  - o_row_ready=1 and o_fifo_i_rd_line=top_slot, both stable for the whole state.
  - A new i_row_req drops o_row_ready the next cycle and goes to CHECK.
- Read path:
  - On i_rd_en in READY, o_fifo_i_rd_addr <= min(i_rd_x, W-1), registered.
  - The matrix adds 1 internally for the 01/11 outputs. At x=W-1, those outputs are undefined and the compute unit must not use them.
- Widths: all counters are IMAGE_WIDTH bits. top_y+2 never exceeds H-1, because y_t <= H-2.

## Timing
- Reset values:
  - All outputs are 0.
  - top_y=0, top_slot=0, state IDLE.
- Frame start to first request:
  - i_frame_start at cycle T gives o_fifo_i_rst at T+1.
  - o_ddr_rd_req for line 0 follows at T+2.
- Write path: zero-cycle passthrough from i_ddr_data_valid to o_fifo_i_wr_en; address is registered and aligned with the beat.
- Last beat of line 1: CHECK is entered on the next cycle.
- Row request when rows are already resident: i_row_req at cycle C gives o_row_ready=1 at C+2.
- Row request that needs one fetch: o_ddr_rd_req at C+2; o_row_ready=1 two cycles after the last beat.
- Read latency: i_rd_en at cycle R gives o_fifo_i_rd_addr at R+1 and o_pix_valid at R+2, matching the RAM plus the matrix's internal line register.
- Mid-operation events:
  - i_frame_start mid-FILL aborts the line; the DDR reader must be flushed by the same pulse.
  - i_row_req while a fetch is busy is ignored.

## Test plan
- Reset with rst_n low mid-FILL -> all outputs 0 the same cycle; IDLE after release; no wr_en on later beats.
- Frame W=8, H=4; feed beats 0..7 per request -> two requests (lines 0, 1), writes addr 0..7 to slot 0 then slot 1; i_row_req y=0 -> o_row_ready, rd_line=0.
- Row y=0 then y=2 -> fetch lines 2 and 3 into slots 0 then 1; final top_slot=0, top_y=2; 00 outputs = line 2 data.
- i_row_y=10 with H=4 -> clamped to y_t=2; no request with line index >3.
- READY; i_rd_en with x=3, then x=9 (W=8) -> rd_addr 3, then 7; o_pix_valid exactly 2 cycles after each strobe.
- i_frame_start mid-FILL with W changed to 16 -> o_fifo_i_rst pulse, line 0 re-requested, writes reach addr 15.

Source files
------------

// File: rtl/input_ram_ctrl.sv
// input_ram_ctrl: two-line input RAM sequencer (frame reset, DDR line fetch, ping-pong write steering, rows y/y+1 read side)
module input_ram_ctrl #(
  parameter int IMAGE_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_frame_start,
  input  logic [IMAGE_WIDTH-1:0] i_src_width,
  input  logic [IMAGE_WIDTH-1:0] i_src_height,
  output logic                   o_ddr_rd_req,
  output logic [IMAGE_WIDTH-1:0] o_ddr_rd_line,
  input  logic                   i_ddr_data_valid,
  output logic                   o_fifo_i_rst,
  output logic                   o_fifo_i_wr_line,
  output logic [IMAGE_WIDTH-1:0] o_fifo_i_wr_addr,
  output logic                   o_fifo_i_wr_en,
  input  logic                   i_row_req,
  input  logic [IMAGE_WIDTH-1:0] i_row_y,
  output logic                   o_row_ready,
  input  logic                   i_rd_en,
  input  logic [IMAGE_WIDTH-1:0] i_rd_x,
  output logic                   o_fifo_i_rd_line,
  output logic [IMAGE_WIDTH-1:0] o_fifo_i_rd_addr,
  output logic                   o_pix_valid
);
  typedef enum logic [2:0] {IDLE, RST, REQ, FILL, CHECK, READY} state_t;
  state_t state_q, state_d;
  logic [IMAGE_WIDTH-1:0] w_q, w_d, h_q, h_d, top_y_q, top_y_d, wr_cnt_q, wr_cnt_d;
  logic [IMAGE_WIDTH-1:0] yt_q, yt_d, ddr_line_q, ddr_line_d, rd_addr_q, rd_addr_d;
  logic [IMAGE_WIDTH-1:0] y_clamp, x_clamp;
  logic top_slot_q, top_slot_d, wr_line_q, wr_line_d, pend_q, pend_d;
  logic rd_v_q, rd_v_d, pix_valid_q, pix_valid_d;
  logic [1:0] fill_idx_q, fill_idx_d;
  logic fill_done;
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    top_y_d     = top_y_q;
    top_slot_d  = top_slot_q;
    wr_cnt_d    = wr_cnt_q;
    wr_line_d   = wr_line_q;
    yt_d        = yt_q;
    pend_d      = pend_q;
    ddr_line_d  = ddr_line_q;
    fill_idx_d  = fill_idx_q;
    fill_done   = fill_idx_q == 2'd2;
    y_clamp     = (i_row_y > h_q - IMAGE_WIDTH'(2)) ? h_q - IMAGE_WIDTH'(2) : i_row_y;
    x_clamp     = (i_rd_x > w_q - IMAGE_WIDTH'(1)) ? w_q - IMAGE_WIDTH'(1) : i_rd_x;
    rd_v_d      = (state_q == READY) && i_rd_en;
    rd_addr_d   = rd_v_d ? x_clamp : rd_addr_q;
    pix_valid_d = rd_v_q;
    unique case (state_q)
      IDLE: ;
      RST:  state_d = REQ;
      REQ:  state_d = FILL;
      FILL: if (i_ddr_data_valid) begin
        wr_cnt_d = wr_cnt_q + IMAGE_WIDTH'(1);
        if (wr_cnt_q == w_q - IMAGE_WIDTH'(1)) begin
          state_d    = CHECK;
          fill_idx_d = fill_done ? fill_idx_q : fill_idx_q + 2'd1;
          top_slot_d = fill_done ? ~top_slot_q : top_slot_q;
          top_y_d    = fill_done ? top_y_q + IMAGE_WIDTH'(1) : top_y_q;
        end
      end
      CHECK: if (!fill_done) state_d = REQ;
      else if (i_row_req) begin
        yt_d   = y_clamp;
        pend_d = 1'b1;
      end else if (pend_q) begin
        state_d = (top_y_q < yt_q) ? REQ : READY;
        pend_d  = top_y_q < yt_q;
      end
      READY: if (i_row_req) begin
        yt_d    = y_clamp;
        pend_d  = 1'b1;
        state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase
    if (i_frame_start) begin
      w_d        = i_src_width;
      h_d        = i_src_height;
      top_y_d    = '0;
      top_slot_d = 1'b0;
      fill_idx_d = 2'd0;
      pend_d     = 1'b0;
      state_d    = RST;
    end
    if (state_d == REQ) begin
      ddr_line_d = fill_done ? top_y_q + IMAGE_WIDTH'(2) : {{(IMAGE_WIDTH-1){1'b0}}, fill_idx_q[0]};
      wr_line_d  = fill_done ? top_slot_q : fill_idx_q[0];
      wr_cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      top_y_q     <= '0;
      top_slot_q  <= 1'b0;
      wr_cnt_q    <= '0;
      wr_line_q   <= 1'b0;
      yt_q        <= '0;
      pend_q      <= 1'b0;
      ddr_line_q  <= '0;
      fill_idx_q  <= 2'd0;
      rd_v_q      <= 1'b0;
      rd_addr_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      top_y_q     <= top_y_d;
      top_slot_q  <= top_slot_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_line_q   <= wr_line_d;
      yt_q        <= yt_d;
      pend_q      <= pend_d;
      ddr_line_q  <= ddr_line_d;
      fill_idx_q  <= fill_idx_d;
      rd_v_q      <= rd_v_d;
      rd_addr_q   <= rd_addr_d;
      pix_valid_q <= pix_valid_d;
    end
  end
  assign o_fifo_i_rst     = state_q == RST;
  assign o_ddr_rd_req     = state_q == REQ;
  assign o_ddr_rd_line    = ddr_line_q;
  assign o_fifo_i_wr_line = wr_line_q;
  assign o_fifo_i_wr_addr = wr_cnt_q;
  assign o_fifo_i_wr_en   = (state_q == FILL) && i_ddr_data_valid;
  assign o_row_ready      = state_q == READY;
  assign o_fifo_i_rd_line = top_slot_q;
  assign o_fifo_i_rd_addr = rd_addr_q;
  assign o_pix_valid      = pix_valid_q;
endmodule

// File: tb/tb_input_ram_ctrl.sv
// tb_input_ram_ctrl: scoreboard bench with randomized frames, a DDR/matrix model and reference expectations
module tb_input_ram_ctrl;
  localparam int IW = 11;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_frame_start = 0, i_ddr_data_valid = 0, i_row_req = 0, i_rd_en = 0;
  logic [IW-1:0] i_src_width = '0, i_src_height = '0, i_row_y = '0, i_rd_x = '0;
  logic o_ddr_rd_req, o_fifo_i_rst, o_fifo_i_wr_line, o_fifo_i_wr_en, o_row_ready, o_fifo_i_rd_line, o_pix_valid;
  logic [IW-1:0] o_ddr_rd_line, o_fifo_i_wr_addr, o_fifo_i_rd_addr;
  logic [15:0] ddr_pix = '0;
  logic [15:0] mem [2][2048];
  logic [15:0] cap_top, cap_bot;
  typedef struct {int c; logic [15:0] top; logic [15:0] bot;} pix_t;
  int exp_req[$];
  int exp_wr[$];
  pix_t exp_pix[$];
  pix_t p;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int mw, mh, mtop, salt;

  input_ram_ctrl #(.IMAGE_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start), .i_src_width(i_src_width),
    .i_src_height(i_src_height), .o_ddr_rd_req(o_ddr_rd_req), .o_ddr_rd_line(o_ddr_rd_line),
    .i_ddr_data_valid(i_ddr_data_valid), .o_fifo_i_rst(o_fifo_i_rst), .o_fifo_i_wr_line(o_fifo_i_wr_line),
    .o_fifo_i_wr_addr(o_fifo_i_wr_addr), .o_fifo_i_wr_en(o_fifo_i_wr_en), .i_row_req(i_row_req),
    .i_row_y(i_row_y), .o_row_ready(o_row_ready), .i_rd_en(i_rd_en), .i_rd_x(i_rd_x),
    .o_fifo_i_rd_line(o_fifo_i_rd_line), .o_fifo_i_rd_addr(o_fifo_i_rd_addr), .o_pix_valid(o_pix_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pix(input int line, input int x);
    return 16'(line * 97 + x * 13 + salt);
  endfunction

  always @(negedge clk) begin
    if (o_ddr_rd_req) begin
      if (exp_req.size() == 0) chk("unexpected_req", o_ddr_rd_line, 32'hffff_ffff);
      else chk("req_line", o_ddr_rd_line, exp_req.pop_front());
    end
    if (o_fifo_i_wr_en) begin
      mem[o_fifo_i_wr_line][o_fifo_i_wr_addr] = ddr_pix;
      if (exp_wr.size() == 0) chk("unexpected_wr", o_fifo_i_wr_addr, 32'hffff_ffff);
      else chk("wr_slot_addr", o_fifo_i_wr_line * 4096 + o_fifo_i_wr_addr, exp_wr.pop_front());
    end
    if (o_pix_valid) begin
      if (exp_pix.size() == 0) chk("unexpected_pix", cap_top, 32'hffff_ffff);
      else begin
        p = exp_pix.pop_front();
        chk("pix_latency", cyc, p.c);
        chk("pix00_top_row", cap_top, p.top);
        chk("pix10_bot_row", cap_bot, p.bot);
      end
    end
    cap_top = mem[o_fifo_i_rd_line][o_fifo_i_rd_addr];
    cap_bot = mem[!o_fifo_i_rd_line][o_fifo_i_rd_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_req"}, o_ddr_rd_req, 0);
    chk({nm, "_rd_line_idx"}, o_ddr_rd_line, 0);
    chk({nm, "_fifo_rst"}, o_fifo_i_rst, 0);
    chk({nm, "_wr_line"}, o_fifo_i_wr_line, 0);
    chk({nm, "_wr_addr"}, o_fifo_i_wr_addr, 0);
    chk({nm, "_wr_en"}, o_fifo_i_wr_en, 0);
    chk({nm, "_row_ready"}, o_row_ready, 0);
    chk({nm, "_rd_slot"}, o_fifo_i_rd_line, 0);
    chk({nm, "_rd_addr"}, o_fifo_i_rd_addr, 0);
    chk({nm, "_pix_valid"}, o_pix_valid, 0);
  endtask

  task automatic feed_line(input int line, input int beats);
    int n = 0;
    while (!o_ddr_rd_req && n < 20) begin
      tick;
      n++;
    end
    chk("req_seen", o_ddr_rd_req, 1);
    tick;
    for (int i = 0; i < beats; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      i_ddr_data_valid = 1;
      ddr_pix = pix(line, i);
      exp_wr.push_back((line % 2) * 4096 + i);
      tick;
      i_ddr_data_valid = 0;
    end
  endtask

  task automatic start_frame(input int w, input int h);
    exp_req.delete();
    exp_wr.delete();
    mw = w; mh = h; mtop = 0;
    salt = $urandom_range(0, 4095);
    exp_req.push_back(0);
    exp_req.push_back(1);
    i_src_width = IW'(w);
    i_src_height = IW'(h);
    i_frame_start = 1;
    tick;
    i_frame_start = 0;
    chk("fifo_rst_T+1", o_fifo_i_rst, 1);
    tick;
    chk("req_T+2", o_ddr_rd_req, 1);
  endtask

  task automatic fill_init;
    feed_line(0, mw);
    feed_line(1, mw);
    tick;
    chk("idle_check_not_ready", o_row_ready, 0);
  endtask

  task automatic row_req(input int y);
    int yt = (y > mh - 2) ? mh - 2 : y;
    int nf;
    if (yt < mtop) yt = mtop;
    nf = yt - mtop;
    for (int k = 0; k < nf; k++) exp_req.push_back(mtop + 2 + k);
    i_row_req = 1;
    i_row_y = IW'(y);
    tick;
    i_row_req = 0;
    chk("ready_low_C+1", o_row_ready, 0);
    tick;
    if (nf == 0) chk("ready_C+2", o_row_ready, 1);
    else begin
      chk("fetch_req_C+2", o_ddr_rd_req, 1);
      for (int k = 0; k < nf; k++) feed_line(mtop + 2 + k, mw);
      chk("ready_low_L+1", o_row_ready, 0);
      tick;
      chk("ready_L+2", o_row_ready, 1);
    end
    chk("rd_slot_top", o_fifo_i_rd_line, yt % 2);
    mtop = yt;
  endtask

  task automatic read(input int x);
    int xc = (x > mw - 1) ? mw - 1 : x;
    exp_pix.push_back('{cyc + 2, pix(mtop, xc), pix(mtop + 1, xc)});
    i_rd_en = 1;
    i_rd_x = IW'(x);
    tick;
    i_rd_en = 0;
    chk("rd_addr_R+1", o_fifo_i_rd_addr, xc);
  endtask

  initial begin
    int y, yr;
    repeat (3) tick;
    chk_outputs_zero("reset");
    rst_n = 1;
    tick;
    start_frame(8, 4);
    fill_init;
    row_req(0);
    read(3);
    read(9);
    repeat (3) tick;
    i_ddr_data_valid = 1;
    repeat (2) tick;
    i_ddr_data_valid = 0;
    row_req(2);
    read(0);
    read(5);
    repeat (2) tick;
    row_req(10);
    row_req(1);
    read(7);
    repeat (3) tick;
    start_frame(8, 4);
    feed_line(0, 3);
    start_frame(16, 4);
    fill_init;
    row_req(1);
    read(15);
    read(20);
    repeat (3) tick;
    start_frame(8, 4);
    feed_line(0, 4);
    rst_n = 0;
    i_ddr_data_valid = 1;
    #1;
    chk_outputs_zero("async_rst");
    exp_req.delete();
    exp_wr.delete();
    tick;
    rst_n = 1;
    repeat (4) tick;
    i_ddr_data_valid = 0;
    chk("idle_after_rst", o_row_ready, 0);
    for (int f = 0; f < 6; f++) begin
      start_frame($urandom_range(2, 20), $urandom_range(2, 9));
      fill_init;
      y = 0;
      for (int r = 0; r < 6; r++) begin
        y += $urandom_range(0, 2);
        yr = ($urandom_range(0, 4) == 0 && y > 0) ? y - 1 : y;
        row_req(yr);
        for (int k = 0; k < 3; k++) read($urandom_range(0, mw + 3));
        repeat ($urandom_range(0, 3)) tick;
      end
      repeat (3) tick;
    end
    repeat (4) tick;
    chk("req_queue_drained", exp_req.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("pix_queue_drained", exp_pix.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
